// File: rtl/marker_pkg.sv
// rtl/marker_pkg.sv - shared types, constants and coordinate helpers for marker_tracker
package marker_pkg;

   localparam int COORD_W = 11;
   localparam int CNT_W   = 20;
   localparam logic [COORD_W-1:0] NOT_FOUND    = 11'd2023;
   localparam logic [COORD_W-1:0] ACC_INIT_MIN = 11'd2047;

   typedef enum logic {S_SYNC, S_SCAN} state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   typedef struct packed {
      point_t l;
      point_t r;
      point_t u;
      point_t d;
   } extremes_t;

   localparam extremes_t NOT_FOUND_PTS = {8{NOT_FOUND}};

   function automatic extremes_t extremes_init();
      extremes_t e;
      e.l = {ACC_INIT_MIN, {COORD_W{1'b0}}};
      e.r = '0;
      e.u = {{COORD_W{1'b0}}, ACC_INIT_MIN};
      e.d = '0;
      return e;
   endfunction

   // 12-bit sum so the midpoint of two 11-bit coordinates never wraps
   function automatic logic [COORD_W-1:0] coord_avg(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
      logic [COORD_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[COORD_W:1];
   endfunction

   function automatic point_t point_avg(input point_t a, input point_t b);
      point_t p;
      p.x = coord_avg(a.x, b.x);
      p.y = coord_avg(a.y, b.y);
      return p;
   endfunction

   function automatic extremes_t extremes_avg(input extremes_t a, input extremes_t b);
      extremes_t e;
      e.l = point_avg(a.l, b.l);
      e.r = point_avg(a.r, b.r);
      e.u = point_avg(a.u, b.u);
      e.d = point_avg(a.d, b.d);
      return e;
   endfunction

endpackage

// File: rtl/color_match.sv
// rtl/color_match.sv - combinational pixel qualifier: active area and red-marker colour window
module color_match #(
   parameter logic [7:0]  R_MIN = 8'd200,
   parameter logic [7:0]  G_MAX = 8'd80,
   parameter logic [7:0]  B_MAX = 8'd80,
   parameter logic [10:0] X_MAX = 11'd640,
   parameter logic [10:0] Y_MAX = 11'd480
) (
   input  logic        valid,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic [7:0]  rgb [3],
   output logic        match
);

   assign match = valid && (x < X_MAX) && (y < Y_MAX) &&
                  (rgb[0] >= R_MIN) && (rgb[1] <= G_MAX) && (rgb[2] <= B_MAX);

endmodule

// File: rtl/marker_tracker.sv
// rtl/marker_tracker.sv - per-frame extreme-point tracker for a colour marker
// Optional output smoothing with the previous publish: MARKER_TRACKER_SMOOTH_EN.
module marker_tracker
   import marker_pkg::*;
#(
   parameter logic [7:0]  R_MIN      = 8'd200,
   parameter logic [7:0]  G_MAX      = 8'd80,
   parameter logic [7:0]  B_MAX      = 8'd80,
   parameter logic [19:0] MIN_PIXELS = 20'd16,
   parameter logic [10:0] X_MAX      = 11'd640,
   parameter logic [10:0] Y_MAX      = 11'd480
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic [7:0]  i_rgb [3],
   input  logic        i_frame_end,
   output logic [10:0] left  [2],
   output logic [10:0] right [2],
   output logic [10:0] up    [2],
   output logic [10:0] down  [2],
   output logic        predict_valid,
   output logic [19:0] o_pix_cnt
);

   state_t           state, state_nxt;
   logic             match, publish, found;
   extremes_t        acc, acc_cls, pts, pts_raw, pts_nxt;
   logic [CNT_W-1:0] cnt, cnt_cls;

   color_match #(
      .R_MIN(R_MIN), .G_MAX(G_MAX), .B_MAX(B_MAX), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
   ) u_color_match (
      .valid(i_valid), .x(x), .y(y), .rgb(i_rgb), .match(match)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_SYNC;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      case (state)
         S_SYNC:  if (i_frame_end) state_nxt = S_SCAN;
         S_SCAN:  publish = i_frame_end;
         default: state_nxt = S_SYNC;
      endcase
   end

   // Closing view of the frame: includes a pixel arriving with i_frame_end
   always_comb begin
      acc_cls = acc;
      cnt_cls = cnt;
      if (state == S_SCAN && match) begin
         if (x < acc.l.x) acc_cls.l = {x, y};
         if (x > acc.r.x) acc_cls.r = {x, y};
         if (y < acc.u.y) acc_cls.u = {x, y};
         if (y > acc.d.y) acc_cls.d = {x, y};
         if (cnt != {CNT_W{1'b1}}) cnt_cls = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc <= extremes_init();
         cnt <= '0;
      end else if (i_frame_end) begin
         acc <= extremes_init();
         cnt <= '0;
      end else begin
         acc <= acc_cls;
         cnt <= cnt_cls;
      end
   end

   assign found   = (cnt_cls >= MIN_PIXELS);
   assign pts_raw = found ? acc_cls : NOT_FOUND_PTS;

`ifdef MARKER_TRACKER_SMOOTH_EN
   logic prev_found;

   assign pts_nxt = (found && prev_found) ? extremes_avg(pts, pts_raw) : pts_raw;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     prev_found <= 1'b0;
      else if (publish) prev_found <= found;
   end
`else
   assign pts_nxt = pts_raw;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pts           <= NOT_FOUND_PTS;
         o_pix_cnt     <= '0;
         predict_valid <= 1'b0;
      end else begin
         predict_valid <= publish;
         if (publish) begin
            pts       <= pts_nxt;
            o_pix_cnt <= cnt_cls;
         end
      end
   end

   assign left[0]  = pts.l.x;
   assign left[1]  = pts.l.y;
   assign right[0] = pts.r.x;
   assign right[1] = pts.r.y;
   assign up[0]    = pts.u.x;
   assign up[1]    = pts.u.y;
   assign down[0]  = pts.d.x;
   assign down[1]  = pts.d.y;

endmodule

// File: tb/tb_marker_tracker.sv
// tb/tb_marker_tracker.sv - randomized self-checking bench for marker_tracker with a queue-based frame model
module tb_marker_tracker;

   localparam int          MIN_PIX = 16;
   localparam logic [10:0] NF      = 11'd2023;

   typedef struct packed { logic [10:0] x; logic [10:0] y; } pt_t;

   logic        clk, rst_n, i_valid, i_frame_end;
   logic [10:0] x, y;
   logic [7:0]  i_rgb [3];
   logic [10:0] left [2], right [2], up [2], down [2];
   logic        predict_valid;
   logic [19:0] o_pix_cnt;

   int assertions = 0;
   int failures   = 0;

   // model state
   pt_t         q[$];
   bit          synced;
   bit          prev_found;
   logic        exp_pv;
   logic [87:0] exp_pts;
   logic [19:0] exp_cnt;

   marker_tracker dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .x(x), .y(y), .i_rgb(i_rgb),
      .i_frame_end(i_frame_end), .left(left), .right(right), .up(up), .down(down),
      .predict_valid(predict_valid), .o_pix_cnt(o_pix_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [87:0] dut_pts();
      return {left[0], left[1], right[0], right[1], up[0], up[1], down[0], down[1]};
   endfunction

   function automatic bit model_match(logic v, logic [10:0] px, logic [10:0] py,
                                      logic [7:0] r, logic [7:0] g, logic [7:0] b);
      return v && px < 11'd640 && py < 11'd480 && r >= 8'd200 && g <= 8'd80 && b <= 8'd80;
   endfunction

   task automatic model_reset();
      q.delete();
      synced     = 0;
      prev_found = 0;
      exp_pv     = 1'b0;
      exp_pts    = {8{NF}};
      exp_cnt    = '0;
   endtask

   task automatic model_publish();
      pt_t         l, r, u, d;
      logic [87:0] raw;
      logic [11:0] s;
      bit          found;
      l = {11'd2047, 11'd0};
      r = '0;
      u = {11'd0, 11'd2047};
      d = '0;
      foreach (q[i]) begin
         if (q[i].x < l.x) l = q[i];
         if (q[i].x > r.x) r = q[i];
         if (q[i].y < u.y) u = q[i];
         if (q[i].y > d.y) d = q[i];
      end
      found = (q.size() >= MIN_PIX);
      raw   = found ? {l, r, u, d} : {8{NF}};
`ifdef MARKER_TRACKER_SMOOTH_EN
      if (found && prev_found) begin
         for (int k = 0; k < 8; k++) begin
            s = {1'b0, exp_pts[k*11 +: 11]} + {1'b0, raw[k*11 +: 11]};
            raw[k*11 +: 11] = s[11:1];
         end
      end
`endif
      exp_pts    = raw;
      exp_cnt    = 20'(q.size());
      prev_found = found;
      exp_pv     = 1'b1;
   endtask

   task automatic step(input logic v, input logic [10:0] px, input logic [10:0] py,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic fe);
      @(negedge clk);
      i_valid = v; x = px; y = py;
      i_rgb[0] = r; i_rgb[1] = g; i_rgb[2] = b;
      i_frame_end = fe;
      @(posedge clk);
      #1;
      i_valid = 1'b0; i_frame_end = 1'b0;
      exp_pv = 1'b0;
      if (synced && model_match(v, px, py, r, g, b)) q.push_back({px, py});
      if (fe) begin
         if (synced) model_publish();
         synced = 1;
         q.delete();
      end
   endtask

   task automatic mpix(input logic [10:0] px, input logic [10:0] py, input logic fe);
      step(1'b1, px, py, 8'd255, 8'd0, 8'd0, fe);
   endtask

   task automatic idle(input logic fe);
      step(1'b0, 11'd0, 11'd0, 8'd0, 8'd0, 8'd0, fe);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_valid = 1'b0; i_frame_end = 1'b0; x = '0; y = '0;
      i_rgb[0] = '0; i_rgb[1] = '0; i_rgb[2] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      assertions++;
      if (dut_pts() !== {8{NF}}) begin
         failures++; $display("FAIL reset_pts got %h want %h", dut_pts(), {8{NF}});
      end
      assertions++;
      if (o_pix_cnt !== 20'd0) begin
         failures++; $display("FAIL reset_cnt got %0d want 0", o_pix_cnt);
      end
      assertions++;
      if (predict_valid !== 1'b0) begin
         failures++; $display("FAIL reset_pv got %b want 0", predict_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_block();
      logic [87:0] want;
      want = {11'd100, 11'd200, 11'd109, 11'd200, 11'd100, 11'd200, 11'd100, 11'd209};
      for (int i = 0; i < 20; i++) mpix(11'(10 + i), 11'd10, 1'b0);
      idle(1'b1);
      assertions++;
      if (predict_valid !== 1'b0) begin
         failures++; $display("FAIL sync_no_publish got %b want 0", predict_valid);
      end
      for (int yy = 200; yy < 210; yy++)
         for (int xx = 100; xx < 110; xx++) mpix(11'(xx), 11'(yy), 1'b0);
      idle(1'b1);
      assertions++;
      if (predict_valid !== exp_pv || exp_pv !== 1'b1) begin
         failures++; $display("FAIL block_pv got %b want %b", predict_valid, exp_pv);
      end
      assertions++;
      if (dut_pts() !== want || exp_pts !== want) begin
         failures++; $display("FAIL block_pts got %h want %h", dut_pts(), want);
      end
      assertions++;
      if (o_pix_cnt !== 20'd100) begin
         failures++; $display("FAIL block_cnt got %0d want 100", o_pix_cnt);
      end
      idle(1'b0);
      assertions++;
      if (predict_valid !== 1'b0) begin
         failures++; $display("FAIL block_pulse_width got %b want 0", predict_valid);
      end
      assertions++;
      if (dut_pts() !== want || o_pix_cnt !== 20'd100) begin
         failures++; $display("FAIL block_hold got %h/%0d want %h/100", dut_pts(), o_pix_cnt, want);
      end
   endtask

   task automatic test_few();
      for (int i = 0; i < 10; i++) mpix(11'(50 + i), 11'(60 + i), 1'b0);
      idle(1'b1);
      assertions++;
      if (predict_valid !== 1'b1) begin
         failures++; $display("FAIL few_pv got %b want 1", predict_valid);
      end
      assertions++;
      if (dut_pts() !== {8{NF}}) begin
         failures++; $display("FAIL few_pts got %h want %h", dut_pts(), {8{NF}});
      end
      assertions++;
      if (o_pix_cnt !== 20'd10) begin
         failures++; $display("FAIL few_cnt got %0d want 10", o_pix_cnt);
      end
   endtask

   task automatic test_back_to_back();
      mpix(11'd300, 11'd50, 1'b1);
      assertions++;
      if (predict_valid !== 1'b1 || o_pix_cnt !== 20'd1 || dut_pts() !== {8{NF}}) begin
         failures++; $display("FAIL same_cycle got pv=%b cnt=%0d want pv=1 cnt=1", predict_valid, o_pix_cnt);
      end
      idle(1'b1);
      assertions++;
      if (predict_valid !== 1'b1 || o_pix_cnt !== 20'd0) begin
         failures++; $display("FAIL b2b_empty got pv=%b cnt=%0d want pv=1 cnt=0", predict_valid, o_pix_cnt);
      end
      mpix(11'd10, 11'd10, 1'b1);
      mpix(11'd20, 11'd20, 1'b0);
      idle(1'b1);
      assertions++;
      if (o_pix_cnt !== exp_cnt || exp_cnt !== 20'd1) begin
         failures++; $display("FAIL new_frame_first_pixel got %0d want 1", o_pix_cnt);
      end
   endtask

   task automatic test_bounds();
      step(1'b1, 11'd640, 11'd10, 8'd255, 8'd0, 8'd0, 1'b0);
      step(1'b1, 11'd10, 11'd480, 8'd255, 8'd0, 8'd0, 1'b0);
      step(1'b1, 11'd20, 11'd20, 8'd199, 8'd0, 8'd0, 1'b0);
      step(1'b1, 11'd21, 11'd21, 8'd255, 8'd81, 8'd0, 1'b0);
      step(1'b1, 11'd22, 11'd22, 8'd255, 8'd0, 8'd81, 1'b0);
      step(1'b0, 11'd23, 11'd23, 8'd255, 8'd0, 8'd0, 1'b0);
      for (int i = 0; i < 16; i++)
         step(1'b1, 11'(639 - i), 11'(479 - 2 * i), 8'd200, 8'd80, 8'd80, 1'b0);
      idle(1'b1);
      assertions++;
      if (o_pix_cnt !== exp_cnt || exp_cnt !== 20'd16) begin
         failures++; $display("FAIL bounds_cnt got %0d want 16", o_pix_cnt);
      end
      assertions++;
      if (dut_pts() !== exp_pts) begin
         failures++; $display("FAIL bounds_pts got %h want %h", dut_pts(), exp_pts);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 50; i++) mpix(11'(200 + i), 11'(300 + i), 1'b0);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      assertions++;
      if (dut_pts() !== {8{NF}} || o_pix_cnt !== 20'd0 || predict_valid !== 1'b0) begin
         failures++; $display("FAIL midreset_out got %h/%0d want all sentinel/0", dut_pts(), o_pix_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) mpix(11'(30 + i), 11'd40, 1'b0);
      idle(1'b1);
      assertions++;
      if (predict_valid !== 1'b0) begin
         failures++; $display("FAIL midreset_nopub got %b want 0", predict_valid);
      end
      for (int i = 0; i < 20; i++) mpix(11'(30 + i), 11'(40 + i), 1'b0);
      idle(1'b1);
      assertions++;
      if (predict_valid !== 1'b1 || dut_pts() !== exp_pts || o_pix_cnt !== exp_cnt) begin
         failures++; $display("FAIL midreset_pub got pv=%b %h/%0d want pv=1 %h/%0d",
                              predict_valid, dut_pts(), o_pix_cnt, exp_pts, exp_cnt);
      end
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 10; f++) begin
         n = $urandom_range(15, 70);
         for (int i = 0; i <= n; i++)
            step(($urandom_range(0, 3) != 0), 11'($urandom_range(0, 700)), 11'($urandom_range(0, 520)),
                 8'($urandom_range(190, 255)), 8'($urandom_range(0, 90)), 8'($urandom_range(0, 90)),
                 (i == n));
         assertions++;
         if (predict_valid !== exp_pv) begin
            failures++; $display("FAIL rand_pv frame %0d got %b want %b", f, predict_valid, exp_pv);
         end
         assertions++;
         if (dut_pts() !== exp_pts) begin
            failures++; $display("FAIL rand_pts frame %0d got %h want %h", f, dut_pts(), exp_pts);
         end
         assertions++;
         if (o_pix_cnt !== exp_cnt) begin
            failures++; $display("FAIL rand_cnt frame %0d got %0d want %0d", f, o_pix_cnt, exp_cnt);
         end
      end
   endtask

`ifdef MARKER_TRACKER_SMOOTH_EN
   task automatic test_smooth();
      idle(1'b1);
      for (int i = 0; i < 16; i++) mpix(11'(100 + i), 11'd100, 1'b0);
      idle(1'b1);
      for (int i = 0; i < 16; i++) mpix(11'(120 + i), 11'd140, 1'b0);
      idle(1'b1);
      assertions++;
      if (left[0] !== 11'd110 || left[1] !== 11'd120 || dut_pts() !== exp_pts) begin
         failures++; $display("FAIL smooth_avg got (%0d,%0d) want (110,120)", left[0], left[1]);
      end
      idle(1'b1);
      assertions++;
      if (dut_pts() !== {8{NF}}) begin
         failures++; $display("FAIL smooth_notfound got %h want sentinel", dut_pts());
      end
      for (int i = 0; i < 16; i++) mpix(11'(80 + i), 11'd80, 1'b0);
      idle(1'b1);
      assertions++;
      if (left[0] !== 11'd80 || left[1] !== 11'd80 || dut_pts() !== exp_pts) begin
         failures++; $display("FAIL smooth_raw got (%0d,%0d) want (80,80)", left[0], left[1]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_block();
      test_few();
      test_back_to_back();
      test_bounds();
      test_reset_mid();
      test_random();
`ifdef MARKER_TRACKER_SMOOTH_EN
      test_smooth();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
